// File: rtl/fila_queue.sv
// fila_queue: byte-wide circular FIFO holding up to DEPTH entries, with a registered pop data output and an occupancy count.
// Latency: one cycle. Every output is a register that updates on the clk_10KHz edge which samples the request.
// Backpressure: there is none. A push into a full queue (without a pop) and a pop from an empty queue are dropped silently.
//
// Ports:
//   clk_10KHz   system clock; all state changes on its rising edge
//   reset       synchronous, active-low; clears pointers, count and data_out
//   data_in     element written on an accepted enqueue
//   enqueue_in  push request, level-sampled each edge
//   dequeue_in  pop request, level-sampled each edge
//   data_out    most recently dequeued element (registered)
//   len_out     number of stored elements, 0..DEPTH (registered)
//
// Build option: FILA_EMPTY_ZERO_EN. When defined, a dequeue on an empty queue
// (with no simultaneous enqueue) loads data_out with 0. When it is undefined,
// data_out holds its previous value.

module fila_queue #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 7,
   parameter int LEN_W  = 3
) (
   input  logic              clk_10KHz,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              enqueue_in,
   input  logic              dequeue_in,
   output logic [DATA_W-1:0] data_out,
   output logic [LEN_W-1:0]  len_out
);

   localparam logic [LEN_W-1:0] FULL_CNT = LEN_W'(DEPTH);
   localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [LEN_W-1:0]  head;
   logic [LEN_W-1:0]  tail;
   logic [LEN_W-1:0]  count;
   logic              is_empty;
   logic              is_full;
   logic              do_push;
   logic              do_pop;

   // DEPTH is not a power of two, so the pointers wrap on an explicit compare
   // and never rely on bit truncation.
   function automatic logic [LEN_W-1:0] next_ptr(input logic [LEN_W-1:0] p);
      return (p == LAST_IDX) ? '0 : p + 1'b1;
   endfunction

   assign is_empty = (count == '0);
   assign is_full  = (count == FULL_CNT);

   // A pop on a full queue frees a slot in the same cycle, so a push is still
   // accepted. On an empty queue only the push is accepted, and data_in is
   // never bypassed to data_out.
   assign do_pop  = dequeue_in && !is_empty;
   assign do_push = enqueue_in && (!is_full || do_pop);

   // The storage array is not reset. Slots that have not been written are
   // never read, because a pop requires count > 0.
   always_ff @(posedge clk_10KHz) begin
      if (reset && do_push) begin
         mem[tail] <= data_in;
      end
   end

   always_ff @(posedge clk_10KHz) begin
      if (!reset) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         data_out <= '0;
      end else begin
         if (do_push) begin
            tail <= next_ptr(tail);
         end
         if (do_pop) begin
            // When the queue is full and a push and pop share an edge,
            // head == tail. The read still sees the old entry, because the
            // write only lands at the end of the cycle.
            data_out <= mem[head];
            head     <= next_ptr(head);
         end
`ifdef FILA_EMPTY_ZERO_EN
         else if (dequeue_in && !enqueue_in && is_empty) begin
            data_out <= '0;
         end
`endif
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign len_out = count;

endmodule

// File: tb/tb_fila_queue.sv
`timescale 1ns/1ps

module tb_fila_queue;

   localparam int DEPTH = 7;

   logic       clk_10KHz = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] data_in = '0;
   logic       enqueue_in = 1'b0;
   logic       dequeue_in = 1'b0;
   logic [7:0] data_out;
   logic [2:0] len_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] len;
      logic [7:0] dat;
      int         step;
   } exp_t;

   exp_t sb[$];

   // Reference model: an unbounded SV queue limited by the capacity rules.
   logic [7:0] model_q[$];
   logic [7:0] model_dat = '0;
   int         step_no = 0;

   fila_queue dut (
      .clk_10KHz (clk_10KHz),
      .reset     (reset),
      .data_in   (data_in),
      .enqueue_in(enqueue_in),
      .dequeue_in(dequeue_in),
      .data_out  (data_out),
      .len_out   (len_out)
   );

   always #5 clk_10KHz = ~clk_10KHz;

   // Drive one edge's worth of requests and record what the queue must show
   // after that edge.
   task automatic cyc(input logic r, input logic e, input logic d, input logic [7:0] x);
      bit pop_ok, push_ok;
      exp_t ex;
      @(negedge clk_10KHz);
      reset = r;
      enqueue_in = e;
      dequeue_in = d;
      data_in = x;
      if (!r) begin
         model_q.delete();
         model_dat = 8'h00;
      end else begin
         pop_ok  = d && (model_q.size() > 0);
         push_ok = e && ((model_q.size() < DEPTH) || pop_ok);
         if (pop_ok) model_dat = model_q.pop_front();
`ifdef FILA_EMPTY_ZERO_EN
         else if (d && !e && model_q.size() == 0) model_dat = 8'h00;
`endif
         if (push_ok) model_q.push_back(x);
      end
      step_no++;
      ex.len = 3'(model_q.size());
      ex.dat = model_dat;
      ex.step = step_no;
      sb.push_back(ex);
   endtask

   task automatic enq(input logic [7:0] x);  cyc(1'b1, 1'b1, 1'b0, x);     endtask
   task automatic deq();                     cyc(1'b1, 1'b0, 1'b1, 8'h00); endtask
   task automatic both(input logic [7:0] x); cyc(1'b1, 1'b1, 1'b1, x);     endtask
   task automatic idle();                    cyc(1'b1, 1'b0, 1'b0, 8'h00); endtask
   task automatic rst();                     cyc(1'b0, 1'b1, 1'b1, 8'hEE); endtask

   // Monitor: the outputs are valid every cycle, so after each edge one
   // expectation is consumed, if one is pending.
   initial begin
      exp_t ex;
      forever begin
         @(posedge clk_10KHz);
         #1;
         if (sb.size() > 0) begin
            ex = sb.pop_front();
            checks++;
            if (len_out !== ex.len) begin
               errors++;
               $display("FAIL len step %0d: got %0d expected %0d", ex.step, len_out, ex.len);
            end
            checks++;
            if (data_out !== ex.dat) begin
               errors++;
               $display("FAIL data step %0d: got %02h expected %02h", ex.step, data_out, ex.dat);
            end
         end
      end
   end

   initial begin
      int r;
      // Reset with both requests high.
      rst();
      // Basic FIFO.
      enq(8'hA1); enq(8'hB2); enq(8'hC3); idle(); deq(); deq(); deq();
      // Full and wrap.
      for (int i = 1; i <= 7; i++) enq(8'(i));
      enq(8'h08);
      deq(); deq(); deq();
      enq(8'h09); enq(8'h0A); enq(8'h0B);
      for (int i = 0; i < 7; i++) deq();
      // Simultaneous enqueue and dequeue.
      enq(8'h11); enq(8'h22); both(8'h33);
      for (int i = 0; i < 5; i++) enq(8'h70 + 8'(i));
      both(8'h7F); both(8'h7E);
      for (int i = 0; i < 7; i++) deq();
      both(8'h44); deq();
      // Underflow.
      enq(8'h55); deq(); deq(); deq();
      // Reset mid-operation.
      enq(8'hC0); enq(8'hC1); enq(8'hC2); rst(); deq(); enq(8'h66); deq();
      // Randomised phases: enqueue-heavy, then dequeue-heavy, then mixed.
      for (int ph = 0; ph < 3; ph++) begin
         for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r == 0) rst();
            else if (ph == 0) cyc(1'b1, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3), 8'($urandom));
            else if (ph == 1) cyc(1'b1, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 7), 8'($urandom));
            else cyc(1'b1, 1'($urandom), 1'($urandom), 8'($urandom));
         end
      end
      idle();
      // Let the monitor consume the remaining expectations.
      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk_10KHz);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
